// File: rtl/uart_tx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_periph : memory-mapped 8N1 UART transmitter with TX FIFO           |
// | Optional even/odd parity bit when UART_TX_PARITY_EN is defined.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_periph #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DEFAULT_DIV = 868
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        rstrb,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq
);

   localparam int          c_AW    = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_START  = 3'd1;
   localparam logic [2:0] c_ST_DATA   = 3'd2;
   localparam logic [2:0] c_ST_PARITY = 3'd3;
   localparam logic [2:0] c_ST_STOP   = 3'd4;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW:0]   r_wptr;
   logic [c_AW:0]   r_rptr;
   logic [2:0]      r_state;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt;
   logic [15:0]     r_baud_cnt;
   logic [15:0]     r_cur_div;
   logic [15:0]     r_baud_div;
   logic            r_overflow;
   logic            r_txd;
   logic [31:0]     r_rdata;
   logic            w_par_odd_bit;

   logic [c_AW:0]   w_count;
   logic            w_full;
   logic            w_empty;
   logic [7:0]      w_head;
   logic [15:0]     w_div;
   logic            w_bit_end;
   logic            w_wr;
   logic            w_wr_data;
   logic            w_push;
   logic            w_pop;
   logic [31:0]     w_status;
   logic            w_unused;

   assign w_count   = r_wptr - r_rptr;
   assign w_full    = (w_count == c_DEPTH);
   assign w_empty   = (w_count == '0);
   assign w_head    = r_mem[r_rptr[c_AW-1:0]];
   assign w_div     = (r_baud_div < 16'd2) ? 16'd2 : r_baud_div;
   assign w_bit_end = (r_baud_cnt == r_cur_div - 16'd1);

   // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
   assign w_wr      = sel & wstrb[0];
   assign w_wr_data = w_wr & (addr == 2'd0);
   assign w_push    = w_wr_data & ~w_full;
   assign w_pop     = ~w_empty & ((r_state == c_ST_IDLE) |
                                  ((r_state == c_ST_STOP) & w_bit_end));

   assign w_status  = {19'd0, w_par_odd_bit,
                       {{(7 - c_AW){1'b0}}, w_count},
                       r_overflow, w_empty, w_full, (r_state != c_ST_IDLE)};

   assign w_unused  = &{1'b0, wdata, wstrb};

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[c_AW-1:0]] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   logic r_par;
   logic r_parity_odd;

   assign w_par_odd_bit = r_parity_odd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_par        <= 1'b0;
         r_parity_odd <= 1'b0;
      end else begin
         if (w_pop) r_par <= ^w_head;
         if (w_wr && addr == 2'd1) r_parity_odd <= wdata[12];
      end
   end
`else
   assign w_par_odd_bit = 1'b0;
`endif

   // Each bit period latches the divisor at its start, so BAUD_DIV writes never stretch a live bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= c_ST_IDLE;
         r_txd      <= 1'b1;
         r_shift    <= 8'd0;
         r_bit_cnt  <= 3'd0;
         r_baud_cnt <= 16'd0;
         r_cur_div  <= 16'd2;
      end else begin
         if (r_state != c_ST_IDLE) begin
            if (w_bit_end) begin
               r_baud_cnt <= 16'd0;
               r_cur_div  <= w_div;
            end else begin
               r_baud_cnt <= r_baud_cnt + 16'd1;
            end
         end
         case (r_state)
            c_ST_IDLE: begin
               if (w_pop) begin
                  r_shift    <= w_head;
                  r_state    <= c_ST_START;
                  r_txd      <= 1'b0;
                  r_baud_cnt <= 16'd0;
                  r_cur_div  <= w_div;
               end
            end
            c_ST_START: begin
               if (w_bit_end) begin
                  r_state   <= c_ST_DATA;
                  r_txd     <= r_shift[0];
                  r_bit_cnt <= 3'd0;
               end
            end
            c_ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= c_ST_PARITY;
                     r_txd   <= r_par ^ r_parity_odd;
`else
                     r_state <= c_ST_STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_txd     <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
            c_ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= c_ST_STOP;
                  r_txd   <= 1'b1;
               end
            end
            c_ST_STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_state <= c_ST_START;
                     r_txd   <= 1'b0;
                  end else begin
                     r_state <= c_ST_IDLE;
                     r_txd   <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baud_div <= 16'(DEFAULT_DIV);
         r_overflow <= 1'b0;
         r_rdata    <= 32'd0;
      end else begin
         if (w_wr && wstrb[1] && addr == 2'd2) r_baud_div <= wdata[15:0];
         if (w_wr_data && w_full)
            r_overflow <= 1'b1;
         else if (w_wr && addr == 2'd1 && wdata[3])
            r_overflow <= 1'b0;
         if (sel && rstrb) begin
            case (addr)
               2'd1:    r_rdata <= w_status;
               2'd2:    r_rdata <= {16'd0, r_baud_div};
               default: r_rdata <= 32'd0;
            endcase
         end
      end
   end

   assign rdata = r_rdata;
   assign txd   = r_txd;
   assign irq   = w_empty & (r_state == c_ST_IDLE);

endmodule
`default_nettype wire
